// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flag_pkg
// Description : Shared constants, types and width helpers for the
//               multi-context flag register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package flag_pkg;

    // Default flag vector width: {N,Z,C,V}
    localparam int NFLAGS_DEF = 4;

    // Bit positions inside a flag vector (N at MSB)
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef logic [NFLAGS_DEF-1:0] flags_t;

    // Width of a pending counter able to hold 0..max_pend
    function automatic int cnt_width(input int max_pend);
        return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
    endfunction

    // Width of a context index; a single context still gets one bit
    function automatic int ctx_width(input int nctx);
        return (nctx < 2) ? 1 : $clog2(nctx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_ctx.sv
`default_nettype none
// ============================================================================
// Module      : flag_ctx
// Description : One flag context: flag register, in-flight op counter and,
//               when FLAG_CKPT_EN is defined, a branch checkpoint register
//               restored on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_ctx
    import flag_pkg::*;
#(
    parameter int NFLAGS   = NFLAGS_DEF,
    parameter int MAX_PEND = 3,
    localparam int PW      = cnt_width(MAX_PEND)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_iss,
    input  logic              i_wr,
    input  logic [NFLAGS-1:0] i_wr_flags,
    input  logic              i_flush,
`ifdef FLAG_CKPT_EN
    input  logic              i_ckpt,
`endif
    output logic [NFLAGS-1:0] o_flags,
    output logic [PW-1:0]     o_pend,
    output logic              o_pend_nz,
    output logic              o_full,
    output logic              o_err
);

    logic [NFLAGS-1:0] r_flags;
    logic [PW-1:0]     r_pend;
    logic              w_full;
    logic              w_pend_nz;
    logic              w_inc;
    logic              w_dec;

    assign w_full    = (r_pend == PW'(MAX_PEND));
    assign w_pend_nz = (r_pend != '0);
    // Issue is dropped when full; a write only retires an op if one exists
    assign w_inc     = i_iss && !w_full;
    assign w_dec     = i_wr && w_pend_nz;

`ifdef FLAG_CKPT_EN
    logic [NFLAGS-1:0] r_ckpt;

    // Checkpoint captures the flags a branch predicted against (with bypass)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ckpt <= '0;
        else if (i_ckpt)
            r_ckpt <= i_wr ? i_wr_flags : r_flags;
    end
`endif

    // Flag register: a flush restores the checkpoint over any same-cycle write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_flags <= '0;
`ifdef FLAG_CKPT_EN
        else if (i_flush)
            r_flags <= r_ckpt;
`endif
        else if (i_wr)
            r_flags <= i_wr_flags;
    end

    // Pending counter: flush wins, simultaneous inc/dec cancel out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_pend <= '0;
        else if (i_flush)
            r_pend <= '0;
        else if (w_inc && !w_dec)
            r_pend <= r_pend + PW'(1);
        else if (w_dec && !w_inc)
            r_pend <= r_pend - PW'(1);
    end

    assign o_flags   = r_flags;
    assign o_pend    = r_pend;
    assign o_pend_nz = w_pend_nz;
    assign o_full    = w_full;
    // Protocol violation: issue into a full counter, or write with none pending
    assign o_err     = (i_iss && w_full) || (i_wr && !w_pend_nz);

endmodule
`default_nettype wire

// File: rtl/flag_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : flag_reg_bank
// Description : Multi-context flag register bank with same-cycle write
//               bypass, per-context in-flight tracking for branch stalls and
//               a sticky protocol-error flag.
//               Optional macro FLAG_CKPT_EN adds per-context flag checkpoints
//               (ports ckpt_en/ckpt_ctx) that are restored on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_reg_bank
    import flag_pkg::*;
#(
    parameter int NFLAGS   = NFLAGS_DEF,
    parameter int NCTX     = 2,
    parameter int MAX_PEND = 3,
    localparam int CTXW    = ctx_width(NCTX),
    localparam int PW      = cnt_width(MAX_PEND)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [CTXW-1:0]   iss_ctx,
    input  logic              wr_en,
    input  logic [CTXW-1:0]   wr_ctx,
    input  logic [NFLAGS-1:0] wr_flags,
    input  logic              flush,
    input  logic [CTXW-1:0]   flush_ctx,
    input  logic [CTXW-1:0]   rd_ctx,
`ifdef FLAG_CKPT_EN
    input  logic              ckpt_en,
    input  logic [CTXW-1:0]   ckpt_ctx,
`endif
    output logic [NFLAGS-1:0] rd_flags,
    output logic              rd_stall,
    output logic [NCTX-1:0]   pend_full,
    output logic              err
);

    logic [NFLAGS-1:0] w_flags [NCTX];
    logic [PW-1:0]     w_pend  [NCTX];
    logic [NCTX-1:0]   w_pend_nz;
    logic [NCTX-1:0]   w_full;
    logic [NCTX-1:0]   w_err_pulse;

    logic [NFLAGS-1:0] w_rd_reg_flags;
    logic [PW-1:0]     w_rd_pend;
    logic              w_rd_nz;
    logic              w_byp;
    logic              r_err;

    genvar g;
    generate
        for (g = 0; g < NCTX; g++) begin : g_ctx
            localparam logic [CTXW-1:0] c_idx = CTXW'(g);

            flag_ctx #(
                .NFLAGS   (NFLAGS),
                .MAX_PEND (MAX_PEND)
            ) u_ctx (
                .clk        (clk),
                .reset      (reset),
                .i_iss      (iss_en && (iss_ctx == c_idx)),
                .i_wr       (wr_en && (wr_ctx == c_idx)),
                .i_wr_flags (wr_flags),
                .i_flush    (flush && (flush_ctx == c_idx)),
`ifdef FLAG_CKPT_EN
                .i_ckpt     (ckpt_en && (ckpt_ctx == c_idx)),
`endif
                .o_flags    (w_flags[g]),
                .o_pend     (w_pend[g]),
                .o_pend_nz  (w_pend_nz[g]),
                .o_full     (w_full[g]),
                .o_err      (w_err_pulse[g])
            );
        end
    endgenerate

    // Select the stored state of the context being read
    always_comb begin
        w_rd_reg_flags = '0;
        w_rd_pend      = '0;
        w_rd_nz        = 1'b0;
        for (int i = 0; i < NCTX; i++) begin
            if (rd_ctx == CTXW'(i)) begin
                w_rd_reg_flags = w_flags[i];
                w_rd_pend      = w_pend[i];
                w_rd_nz        = w_pend_nz[i];
            end
        end
    end

    // Bypass is masked during reset so outputs read zero immediately
    assign w_byp    = reset && wr_en && (wr_ctx == rd_ctx);
    assign rd_flags = w_byp ? wr_flags : w_rd_reg_flags;
    // A same-cycle write retires one op, so stall only if more remain
    assign rd_stall = w_byp ? (w_rd_pend > PW'(1)) : w_rd_nz;

    // Sticky error collects any context's protocol violation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err <= 1'b0;
        else if (|w_err_pulse)
            r_err <= 1'b1;
    end

    assign pend_full = w_full;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_flag_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_reg_bank
// Description : Self-checking bench for flag_reg_bank with a behavioural
//               model compared every cycle plus directed literal checks.
//               Honours FLAG_CKPT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_reg_bank;
    import flag_pkg::*;

    localparam int NFLAGS   = 4;
    localparam int NCTX     = 2;
    localparam int MAX_PEND = 3;
    localparam int CTXW     = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              iss_en = 1'b0;
    logic [CTXW-1:0]   iss_ctx = '0;
    logic              wr_en = 1'b0;
    logic [CTXW-1:0]   wr_ctx = '0;
    flags_t            wr_flags = '0;
    logic              flush = 1'b0;
    logic [CTXW-1:0]   flush_ctx = '0;
    logic [CTXW-1:0]   rd_ctx = '0;
`ifdef FLAG_CKPT_EN
    logic              ckpt_en = 1'b0;
    logic [CTXW-1:0]   ckpt_ctx = '0;
`endif
    logic [NFLAGS-1:0] rd_flags;
    logic              rd_stall;
    logic [NCTX-1:0]   pend_full;
    logic              err;

    flag_reg_bank #(
        .NFLAGS   (NFLAGS),
        .NCTX     (NCTX),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iss_en    (iss_en),
        .iss_ctx   (iss_ctx),
        .wr_en     (wr_en),
        .wr_ctx    (wr_ctx),
        .wr_flags  (wr_flags),
        .flush     (flush),
        .flush_ctx (flush_ctx),
        .rd_ctx    (rd_ctx),
`ifdef FLAG_CKPT_EN
        .ckpt_en   (ckpt_en),
        .ckpt_ctx  (ckpt_ctx),
`endif
        .rd_flags  (rd_flags),
        .rd_stall  (rd_stall),
        .pend_full (pend_full),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_flags [NCTX];
    logic [3:0] m_ckpt  [NCTX];
    int         m_pend  [NCTX];
    bit         m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCTX; c++) begin
                m_flags[c] = '0;
                m_ckpt[c]  = '0;
                m_pend[c]  = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int c = 0; c < NCTX; c++) begin
                bit is_iss, is_wr, is_fl, is_ck;
                logic [3:0] old_f, old_k;
                is_iss = iss_en && (iss_ctx == c);
                is_wr  = wr_en && (wr_ctx == c);
                is_fl  = flush && (flush_ctx == c);
                is_ck  = 1'b0;
`ifdef FLAG_CKPT_EN
                is_ck  = ckpt_en && (ckpt_ctx == c);
`endif
                old_f = m_flags[c];
                old_k = m_ckpt[c];
                if (is_iss && m_pend[c] == MAX_PEND) m_err = 1'b1;
                if (is_wr && m_pend[c] == 0) m_err = 1'b1;
                if (is_wr) m_flags[c] = wr_flags;
`ifdef FLAG_CKPT_EN
                if (is_fl) m_flags[c] = old_k;
`endif
                if (is_ck) m_ckpt[c] = is_wr ? wr_flags : old_f;
                if (is_fl)
                    m_pend[c] = 0;
                else
                    m_pend[c] = m_pend[c]
                              + ((is_iss && m_pend[c] < MAX_PEND) ? 1 : 0)
                              - ((is_wr && m_pend[c] > 0) ? 1 : 0);
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (cmp_on) begin
            bit byp;
            logic [3:0] e_flags;
            logic [1:0] e_full;
            byp     = reset && wr_en && (wr_ctx == rd_ctx);
            e_flags = byp ? wr_flags : m_flags[rd_ctx];
            for (int c = 0; c < NCTX; c++) e_full[c] = (m_pend[c] == MAX_PEND);
            chk("model_rd_flags", rd_flags, e_flags);
            chk("model_rd_stall", rd_stall, m_pend[rd_ctx] > (byp ? 1 : 0));
            chk("model_pend_full", pend_full, e_full);
            chk("model_err", err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cmp_on = 1'b1;

        // Reset then idle
        repeat (3) tick();
        settle();
        chk("idle_rd_flags", rd_flags, 4'b0000);
        chk("idle_rd_stall", rd_stall, 1'b0);
        chk("idle_pend_full", pend_full, 2'b00);
        chk("idle_err", err, 1'b0);

        // Issue ctx0, then write it with bypass
        rd_ctx = 0; iss_en = 1; iss_ctx = 0;
        tick();
        iss_en = 0;
        settle();
        chk("issue_stall", rd_stall, 1'b1);
        wr_en = 1; wr_ctx = 0; wr_flags = 4'b1010;
        settle();
        chk("bypass_flags", rd_flags, 4'b1010);
        chk("bypass_stall", rd_stall, 1'b0);
        tick();
        wr_en = 0;
        settle();
        chk("commit_flags", rd_flags, 4'b1010);
        chk("commit_stall", rd_stall, 1'b0);
        chk("legal_err", err, 1'b0);

`ifdef FLAG_CKPT_EN
        // Checkpoint ctx1 as 1000 via a legal issue/write pair
        iss_en = 1; iss_ctx = 1;
        tick();
        iss_en = 0;
        wr_en = 1; wr_ctx = 1; wr_flags = 4'b1000; ckpt_en = 1; ckpt_ctx = 1;
        tick();
        wr_en = 0; ckpt_en = 0;
`endif

        // Fill ctx1 and overflow it
        rd_ctx = 1; iss_en = 1; iss_ctx = 1;
        tick(); tick(); tick();
        settle();
        chk("full_pend_full", pend_full, 2'b10);
        chk("full_err_clear", err, 1'b0);
        tick();
        iss_en = 0;
        settle();
        chk("overflow_err", err, 1'b1);
        chk("overflow_full", pend_full, 2'b10);
        wr_en = 1; wr_ctx = 1; wr_flags = 4'b0100;
        settle();
        chk("three_pend_byp_flags", rd_flags, 4'b0100);
        chk("three_pend_byp_stall", rd_stall, 1'b1);
        tick();
        wr_en = 0;
        settle();
        chk("two_pend_stall", rd_stall, 1'b1);
        chk("two_pend_full", pend_full, 2'b00);

        // Simultaneous issue and write on ctx0 with counter 1
        iss_en = 1; iss_ctx = 0;
        tick();
        wr_en = 1; wr_ctx = 0; wr_flags = 4'b0110;
        tick();
        iss_en = 0; wr_en = 0; rd_ctx = 0;
        settle();
        chk("iss_wr_stall", rd_stall, 1'b1);
        chk("iss_wr_flags", rd_flags, 4'b0110);
        rd_ctx = 1;
        settle();
        chk("ctx1_untouched_flags", rd_flags, 4'b0100);
        chk("ctx1_untouched_stall", rd_stall, 1'b1);

        // Flush ctx1 with a same-cycle write
        flush = 1; flush_ctx = 1; wr_en = 1; wr_ctx = 1; wr_flags = 4'b0011;
        tick();
        flush = 0; wr_en = 0;
        settle();
        chk("flush_stall", rd_stall, 1'b0);
`ifdef FLAG_CKPT_EN
        chk("flush_flags", rd_flags, 4'b1000);
`else
        chk("flush_flags", rd_flags, 4'b0011);
`endif
        rd_ctx = 0;
        settle();
        chk("flush_other_flags", rd_flags, 4'b0110);
        chk("flush_other_stall", rd_stall, 1'b1);

        // Asynchronous reset mid-burst
        iss_en = 1; iss_ctx = 1;
        tick(); tick(); tick();
        iss_en = 1; iss_ctx = 0;
        tick();
        iss_en = 0;
        settle();
        chk("pre_reset_full", pend_full, 2'b10);
        wr_en = 1; wr_ctx = 0; wr_flags = 4'b1111;
        settle();
        reset = 1'b0;
        settle();
        chk("async_rst_flags", rd_flags, 4'b0000);
        chk("async_rst_stall", rd_stall, 1'b0);
        chk("async_rst_full", pend_full, 2'b00);
        chk("async_rst_err", err, 1'b0);
        wr_en = 0;
        tick(); tick();
        reset = 1'b1;
        rd_ctx = 1;
        settle();
        chk("post_rst_flags", rd_flags, 4'b0000);
        chk("post_rst_stall", rd_stall, 1'b0);

        // Write with no pending op: flags committed, error raised
        rd_ctx = 0; wr_en = 1; wr_ctx = 0; wr_flags = 4'b1001;
        tick();
        wr_en = 0;
        settle();
        chk("underflow_flags", rd_flags, 4'b1001);
        chk("underflow_err", err, 1'b1);
        chk("underflow_stall", rd_stall, 1'b0);

        repeat (3) tick();
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
